// File: rtl/control_pipe.sv
// RV32I(M) control unit: decodes in D and registers the bundle into E (hold/flush, 1-cycle latency).
// Multi-cycle MUL/DIV sequencing holds F/D/E via stall_req for LAT cycles, then pulses mdu_done.
module control_pipe #(
  parameter bit ENABLE_M = 1'b1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcodeD,
  input  logic [2:0] funct3D,
  input  logic [6:0] funct7D,
  input  logic       flagE,
  input  logic       stallE,
  input  logic       flushE,
  output logic [2:0] immsrcD,
  output logic       illegalD,
  output logic       regwriteE,
  output logic       memwriteE,
  output logic       alusrcE,
  output logic       jalrE,
  output logic [1:0] resultsrcE,
  output logic [2:0] aluopE,
  output logic       mdu_selE,
  output logic [2:0] mdu_opE,
  output logic       illegalE,
  output logic       pcsrcE,
  output logic       stall_req,
  output logic       mdu_done
);

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       alusrc;
    logic       jalr;
    logic       branch;
    logic       jump;
    logic [1:0] resultsrc;
    logic [2:0] aluop;
    logic       mdu_sel;
    logic [2:0] mdu_op;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  ctrl_t            dec;
  ctrl_t            ctrl_d, ctrl_q;
  logic [2:0]       immsrc;
  logic             illegal;
  logic             is_m;
  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    dec     = '0;
    immsrc  = 3'b000;
    illegal = 1'b0;
    is_m    = (funct7D == 7'b0000001);
    case (opcodeD)
      7'b0000011: begin
        dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.resultsrc = 2'b01; dec.aluop = 3'b010;
      end
      7'b0100011: begin
        immsrc = 3'b001; dec.memwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 3'b011;
      end
      7'b0110011: begin
        if (is_m && !ENABLE_M) begin
          illegal = 1'b1;
        end else begin
          dec.regwrite = 1'b1;
          dec.mdu_sel  = is_m;
          dec.mdu_op   = is_m ? funct3D : 3'b000;
        end
      end
      7'b1100011: begin
        immsrc = 3'b010; dec.branch = 1'b1; dec.aluop = 3'b100;
      end
      7'b0010011: begin
        dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 3'b001;
      end
      7'b1101111: begin
        immsrc = 3'b100; dec.regwrite = 1'b1; dec.jump = 1'b1;
        dec.resultsrc = 2'b10; dec.aluop = 3'b101;
      end
      7'b1100111: begin
        dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.jalr = 1'b1;
        dec.resultsrc = 2'b10; dec.aluop = 3'b101;
      end
      7'b0110111: begin
        immsrc = 3'b011; dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 3'b110;
      end
      7'b0010111: begin
        immsrc = 3'b011; dec.regwrite = 1'b1; dec.alusrc = 1'b1;
        dec.resultsrc = 2'b11; dec.aluop = 3'b111;
      end
      default: illegal = 1'b1;
    endcase
    dec.illegal = illegal;
  end

  assign immsrcD  = immsrc;
  assign illegalD = illegal;

  // An MDU stall outranks the hazard unit's flush/hold so the M op can never be lost mid-flight.
  always_comb begin
    ctrl_d = ctrl_q;
    if (stall_req)   ctrl_d = ctrl_q;
    else if (flushE) ctrl_d = '0;
    else if (stallE) ctrl_d = ctrl_q;
    else             ctrl_d = dec;
  end

  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  end

  assign regwriteE  = ctrl_q.regwrite;
  assign memwriteE  = ctrl_q.memwrite;
  assign alusrcE    = ctrl_q.alusrc;
  assign jalrE      = ctrl_q.jalr;
  assign resultsrcE = ctrl_q.resultsrc;
  assign aluopE     = ctrl_q.aluop;
  assign mdu_selE   = ctrl_q.mdu_sel;
  assign mdu_opE    = ctrl_q.mdu_op;
  assign illegalE   = ctrl_q.illegal;
  assign pcsrcE     = (ctrl_q.branch & flagE) | ctrl_q.jump | ctrl_q.jalr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The BUSY-exit cycle never restarts; a back-to-back M op is picked up in the following IDLE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ctrl_q.mdu_sel) begin
          state_d = BUSY;
          cnt_d   = ctrl_q.mdu_op[2] ? DIV_CNT : MUL_CNT;
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_req = 1'b0;
    mdu_done  = 1'b0;
    case (state_q)
      IDLE: stall_req = ctrl_q.mdu_sel;
      BUSY: begin
        if (cnt_q != '0) stall_req = 1'b1;
        else             mdu_done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_pipe.sv
// Directed-vector bench for control_pipe: default build plus an ENABLE_M=0 build sharing inputs.
module tb_control_pipe;

  logic       clk;
  logic       rst;
  logic [6:0] opcodeD;
  logic [2:0] funct3D;
  logic [6:0] funct7D;
  logic       flagE, stallE, flushE;

  logic [2:0] immsrcD;
  logic       illegalD, regwriteE, memwriteE, alusrcE, jalrE;
  logic [1:0] resultsrcE;
  logic [2:0] aluopE, mdu_opE;
  logic       mdu_selE, illegalE, pcsrcE, stall_req, mdu_done;

  logic [2:0] m0_immsrcD;
  logic       m0_illegalD, m0_regwriteE, m0_memwriteE, m0_alusrcE, m0_jalrE;
  logic [1:0] m0_resultsrcE;
  logic [2:0] m0_aluopE, m0_mdu_opE;
  logic       m0_mdu_selE, m0_illegalE, m0_pcsrcE, m0_stall_req, m0_mdu_done;

  int vecs = 0;
  int errs = 0;
  logic [15:0] sv, dv;

  localparam logic [6:0] OP_R = 7'b0110011, OP_S = 7'b0100011, OP_B = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_BAD = 7'b1111111;

  control_pipe #(.ENABLE_M(1'b1), .MUL_LAT(3), .DIV_LAT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcodeD(opcodeD), .funct3D(funct3D), .funct7D(funct7D),
    .flagE(flagE), .stallE(stallE), .flushE(flushE),
    .immsrcD(immsrcD), .illegalD(illegalD), .regwriteE(regwriteE), .memwriteE(memwriteE),
    .alusrcE(alusrcE), .jalrE(jalrE), .resultsrcE(resultsrcE), .aluopE(aluopE),
    .mdu_selE(mdu_selE), .mdu_opE(mdu_opE), .illegalE(illegalE), .pcsrcE(pcsrcE),
    .stall_req(stall_req), .mdu_done(mdu_done)
  );

  control_pipe #(.ENABLE_M(1'b0), .MUL_LAT(3), .DIV_LAT(8), .CNT_W(4)) dut_m0 (
    .clk(clk), .rst(rst), .opcodeD(opcodeD), .funct3D(funct3D), .funct7D(funct7D),
    .flagE(flagE), .stallE(stallE), .flushE(flushE),
    .immsrcD(m0_immsrcD), .illegalD(m0_illegalD), .regwriteE(m0_regwriteE),
    .memwriteE(m0_memwriteE), .alusrcE(m0_alusrcE), .jalrE(m0_jalrE),
    .resultsrcE(m0_resultsrcE), .aluopE(m0_aluopE), .mdu_selE(m0_mdu_selE),
    .mdu_opE(m0_mdu_opE), .illegalE(m0_illegalE), .pcsrcE(m0_pcsrcE),
    .stall_req(m0_stall_req), .mdu_done(m0_mdu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcodeD = op;
    funct3D = f3;
    funct7D = f7;
  endtask

  function automatic logic [15:0] e_bundle();
    return {3'b0, regwriteE, memwriteE, alusrcE, jalrE, resultsrcE, aluopE, mdu_selE, mdu_opE};
  endfunction

  initial begin
    rst = 1'b1;
    opcodeD = 7'($urandom); funct3D = 3'($urandom); funct7D = 7'($urandom);
    flagE = 1'($urandom); stallE = 1'($urandom); flushE = 1'($urandom);
    step(); step();
    chk("reset_bundle", e_bundle(), 16'h0);
    chk("reset_misc", {11'b0, illegalE, pcsrcE, stall_req, mdu_done, m0_stall_req}, 16'h0);

    // add
    set_d(OP_R, 3'b000, 7'b0000000); flagE = 1'b0; stallE = 1'b0; flushE = 1'b0; rst = 1'b0;
    step();
    chk("add_e", e_bundle(), 16'h1000);
    chk("add_m0_e", {14'b0, m0_regwriteE, m0_illegalE}, 16'h2);

    // store
    set_d(OP_S, 3'b010, 7'b0); #1;
    chk("sw_immsrc", {12'b0, illegalD, immsrcD}, 16'h1);
    step();
    chk("sw_e", {14'b0, memwriteE, regwriteE}, 16'h2);

    // branch taken / not taken
    set_d(OP_B, 3'b000, 7'b0); flagE = 1'b1; #1;
    chk("beq_immsrc", {13'b0, immsrcD}, 16'h2);
    step();
    chk("beq_taken", {15'b0, pcsrcE}, 16'h1);
    flagE = 1'b0; #1;
    chk("beq_not_taken", {15'b0, pcsrcE}, 16'h0);

    set_d(OP_JAL, 3'b000, 7'b0); step();
    chk("jal", {12'b0, pcsrcE, jalrE, resultsrcE}, 16'hA);
    set_d(OP_JALR, 3'b000, 7'b0); step();
    chk("jalr", {12'b0, pcsrcE, jalrE, resultsrcE}, 16'hE);

    // back-to-back MUL, D held on MUL
    set_d(OP_R, 3'b000, 7'b0000001); step();
    sv = '0; dv = '0;
    for (int i = 0; i < 8; i++) begin
      sv = {sv[14:0], stall_req}; dv = {dv[14:0], mdu_done};
      if (i == 7) set_d(OP_R, 3'b000, 7'b0000000);
      if (i < 7) step();
    end
    chk("mul_stall", sv, 16'h00EE);
    chk("mul_done", dv, 16'h0011);
    step();
    chk("mul_next_e", e_bundle(), 16'h1000);
    chk("mul_next_stall", {15'b0, stall_req}, 16'h0);

    // DIV with flush in stall cycle 2 and stallE in stall cycle 5
    set_d(OP_R, 3'b100, 7'b0000001); step();
    set_d(OP_R, 3'b000, 7'b0000000);
    sv = '0; dv = '0;
    for (int i = 1; i <= 10; i++) begin
      flushE = (i == 2); stallE = (i == 5);
      sv = {sv[14:0], stall_req}; dv = {dv[14:0], mdu_done};
      if (i == 5) chk("div_op_busy", {12'b0, mdu_selE, mdu_opE}, 16'hC);
      if (i < 10) step();
    end
    flushE = 1'b0; stallE = 1'b0;
    chk("div_stall", sv, 16'h03FC);
    chk("div_done", dv, 16'h0002);
    chk("div_next_e", e_bundle(), 16'h1000);

    // DIV aborted by reset in stall cycle 4
    set_d(OP_R, 3'b100, 7'b0000001); step();
    set_d(OP_R, 3'b000, 7'b0000000);
    step(); step(); step();
    chk("divrst_busy", {15'b0, stall_req}, 16'h1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("divrst_idle", {13'b0, stall_req, mdu_done, mdu_selE}, 16'h0);
    dv = '0;
    for (int i = 0; i < 4; i++) begin
      step(); dv = {dv[14:0], mdu_done | stall_req};
    end
    chk("divrst_no_done", dv, 16'h0);

    // flush + stall together: flush wins
    set_d(OP_S, 3'b010, 7'b0); flushE = 1'b1; stallE = 1'b1; step();
    chk("flush_over_stall", e_bundle(), 16'h0);
    flushE = 1'b0; stallE = 1'b0; step();
    set_d(OP_R, 3'b000, 7'b0); stallE = 1'b1; step();
    chk("stall_hold", {14'b0, memwriteE, regwriteE}, 16'h2);
    stallE = 1'b0;

    // M encoding with ENABLE_M=0
    set_d(OP_R, 3'b000, 7'b0000001); #1;
    chk("m0_illegalD", {14'b0, m0_illegalD, illegalD}, 16'h2);
    step();
    chk("m0_illegalE", {12'b0, m0_illegalE, m0_regwriteE, m0_mdu_selE, m0_stall_req}, 16'h8);
    set_d(OP_R, 3'b000, 7'b0000000);
    step(); step(); step(); step();
    chk("m0_main_drained", {14'b0, stall_req, regwriteE & ~mdu_selE}, 16'h1);

    // unknown opcode
    set_d(OP_BAD, 3'b111, 7'b1111111); flagE = 1'b1; #1;
    chk("bad_illegalD", {12'b0, illegalD, immsrcD}, 16'h8);
    step();
    chk("bad_e", e_bundle(), 16'h0);
    chk("bad_misc", {13'b0, illegalE, pcsrcE, stall_req}, 16'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
# control_pipe

Parametrised second-generation control unit for the pipelined RV32I core. It decodes opcode/funct fields in Decode and registers the control bundle into the Execute stage with stall/flush handling. It resolves the PC source in Execute and sequences multi-cycle M-extension (MUL/DIV) operations with a stall request to the hazard unit. It sits between the Decode-stage instruction fields and the Execute-stage datapath muxes.

## Interface
Parameters:
- ENABLE_M, 1, 1 = decode RV32M (opcode 0110011, funct7 0000001); 0 = such encodings are illegal
- MUL_LAT, 3, stall cycles for funct3[2]=0 M ops; legal range 1..15
- DIV_LAT, 8, stall cycles for funct3[2]=1 M ops; legal range 1..15
- CNT_W, 4, width of the latency counter

Ports:
- clk  in  1  single clock; everything updates on the rising edge
- rst  in  1  synchronous, active-high reset
- opcodeD  in  7  instr[6:0] in Decode
- funct3D  in  3  instr[14:12]
- funct7D  in  7  instr[31:25]
- flagE  in  1  branch-condition result from the Execute ALU
- stallE  in  1  external Execute hold from the hazard unit
- flushE  in  1  external Execute bubble insert
- immsrcD  out  3  combinational immediate select (I=000, S=001, B=010, U=011, J=100)
- illegalD  out  1  combinational: opcode not in the 9 RV32I classes, or an M op with ENABLE_M=0
- regwriteE, memwriteE, alusrcE, jalrE  out  1 each  registered controls
- resultsrcE  out  2  00 ALU, 01 load, 10 PC+4, 11 auipc
- aluopE  out  3  000 R, 001 I, 010 load, 011 S, 100 B, 101 jal/jalr, 110 lui, 111 auipc
- mdu_selE  out  1  Execute holds an M op; selects the MDU result into the ALU-result path
- mdu_opE  out  3  registered funct3 of the M op
- illegalE  out  1  registered illegalD
- pcsrcE  out  1  combinational: (branchE & flagE) | jumpE | jalrE
- stall_req  out  1  freeze F/D/E while the MDU is busy
- mdu_done  out  1  one-cycle pulse when the MDU result is valid

## Operation
- Decode table: identical encodings to the single-cycle control. The R-type M op sets regwrite=1, alusrc=0, aluop=000, resultsrc=00, mdu_sel=1.
- Illegal opcode: the entire bundle decodes to zero (NOP) and illegalD=1.
- Internal registered bits branchE (opcode 1100011) and jumpE (opcode 1101111) feed pcsrcE.
- E register update priority, highest first:
  1. rst: clear all.
  2. stall_req: hold; flushE and stallE are ignored.
  3. flushE: clear to NOP.
  4. stallE: hold.
  5. Otherwise load the Decode bundle.
- MDU FSM states: IDLE and BUSY. cnt is CNT_W bits.
  - IDLE and mdu_selE=1: stall_req=1, cnt<=LAT-1, where LAT=MUL_LAT if mdu_opE[2]=0 and DIV_LAT otherwise. Next state BUSY.
  - BUSY and cnt!=0: stall_req=1, cnt<=cnt-1.
  - BUSY and cnt==0: stall_req=0, mdu_done=1, next state IDLE. The E register loads the next instruction on this same edge.
  - A BUSY-exit cycle never restarts the FSM. A back-to-back M op is detected in the following IDLE cycle.
- stall_req and mdu_done are combinational from state, cnt and mdu_selE.

## Timing
- Reset: all E outputs 0, illegalE 0, state IDLE, cnt 0, stall_req 0, mdu_done 0. pcsrcE is 0 after reset.
- Decode-to-Execute latency is 1 cycle. immsrcD and illegalD have 0 latency.
- An M op occupies Execute for LAT+1 cycles: stall_req is high for exactly LAT cycles, then mdu_done is high for 1 cycle.
- With LAT=1: stall_req is high for 1 cycle and mdu_done follows in the next cycle.
- rst during BUSY: the FSM returns to IDLE on the next edge, and no mdu_done pulse is produced.
- flushE or stallE during BUSY has no effect. The M op completes.
- flushE together with stallE, with stall_req low: flush wins and the E register becomes NOP.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> every output is 0 and stall_req=0.
- Decode: opcode 0110011 (add) -> next cycle regwriteE=1, aluopE=000, alusrcE=0, mdu_selE=0. Opcode 0100011 -> immsrcD=001 same cycle; next cycle memwriteE=1, regwriteE=0.
- Branch and jumps: beq loaded with flagE=1 -> pcsrcE=1. Same with flagE=0 -> pcsrcE=0. jal or jalr -> pcsrcE=1 regardless of flagE; jalr also gives jalrE=1.
- MUL: funct7=0000001, funct3=000, MUL_LAT=3 -> stall_req high for 3 cycles, mdu_done in cycle 4, next instruction in E in cycle 5. A back-to-back MUL repeats the same pattern.
- DIV: funct3=100, DIV_LAT=8, with flushE pulsed in stall cycle 2 -> stall_req still high for 8 cycles and mdu_done in cycle 9. Separately, rst asserted in stall cycle 4 -> IDLE next cycle and no mdu_done.
- Illegal: ENABLE_M=0 with an M encoding, and opcode 1111111 -> illegalD=1, next cycle illegalE=1 with all controls 0 and no stall.
